// File: rtl/cla_arbiter.sv
// ---------------------------------------------------------------------------
// cla_arbiter
//
// Shares a single 32-bit carry-lookahead adder slice between two requesters
// and sequences it to add WORDS*32-bit operands, one 32-bit slice per cycle,
// with the inter-slice carry held in a register.
//
// Parameters
//   WORDS          number of 32-bit slices per operation (1..8)
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   req0_valid     requester 0 has an operation
//   req0_ready     requester 0 operation accepted this cycle
//   req0_a/b       requester 0 operands (32*WORDS bits)
//   req0_cin       requester 0 carry-in
//   req0_sub       requester 0 subtract select (ADD_ARB_SUB_EN only)
//   req1_*         same set for requester 1
//   rsp_valid      result available
//   rsp_ready      consumer accepts result
//   rsp_id         requester the result belongs to
//   rsp_sum        result (modulo 2^(32*WORDS))
//   rsp_cout       carry-out of the top slice (no-borrow flag when subtracting)
//
// Build option
//   ADD_ARB_SUB_EN adds req0_sub/req1_sub; sub=1 computes a-b by inverting b
//                  slice by slice and forcing the first carry-in to 1.
// ---------------------------------------------------------------------------

// 32-bit two-level carry-lookahead adder: 4-bit groups with in-group
// lookahead, and group generate/propagate rippled across the 8 groups.
module Cla32Slice (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_cin,
   output logic [31:0] o_sum,
   output logic        o_cout
);

   // Bit generate/propagate, group terms, then every bit carry expressed
   // directly from its group carry-in so no carry ripples inside a group.
   always_comb begin
      logic [31:0] w_g;
      logic [31:0] w_p;
      logic [31:0] w_c;
      logic [7:0]  w_gg;
      logic [7:0]  w_gp;
      logic [8:0]  w_gc;
      w_g   = i_a & i_b;
      w_p   = i_a ^ i_b;
      w_c   = '0;
      w_gg  = '0;
      w_gp  = '0;
      w_gc  = '0;
      w_gc[0] = i_cin;
      for (int j = 0; j < 8; j++) begin
         w_gp[j] = &w_p[4*j +: 4];
         w_gg[j] = w_g[4*j+3]
                 | (w_p[4*j+3] & w_g[4*j+2])
                 | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                 | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
         w_gc[j+1] = w_gg[j] | (w_gp[j] & w_gc[j]);
         w_c[4*j]   = w_gc[j];
         w_c[4*j+1] = w_g[4*j] | (w_p[4*j] & w_gc[j]);
         w_c[4*j+2] = w_g[4*j+1]
                    | (w_p[4*j+1] & w_g[4*j])
                    | (w_p[4*j+1] & w_p[4*j] & w_gc[j]);
         w_c[4*j+3] = w_g[4*j+2]
                    | (w_p[4*j+2] & w_g[4*j+1])
                    | (w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                    | (w_p[4*j+2] & w_p[4*j+1] & w_p[4*j] & w_gc[j]);
      end
      o_sum  = w_p ^ w_c;
      o_cout = w_gc[8];
   end

endmodule

module cla_arbiter #(
   parameter int WORDS = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [32*WORDS-1:0]   req0_a,
   input  logic [32*WORDS-1:0]   req0_b,
   input  logic                  req0_cin,
`ifdef ADD_ARB_SUB_EN
   input  logic                  req0_sub,
`endif
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [32*WORDS-1:0]   req1_a,
   input  logic [32*WORDS-1:0]   req1_b,
   input  logic                  req1_cin,
`ifdef ADD_ARB_SUB_EN
   input  logic                  req1_sub,
`endif
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_id,
   output logic [32*WORDS-1:0]   rsp_sum,
   output logic                  rsp_cout
);

   localparam int W = 32 * WORDS;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         r_state;
   logic [3:0]     r_k;
   logic           r_carry;
   logic           r_lastGrant;
   logic [W-1:0]   r_a;
   logic [W-1:0]   r_b;
   logic           r_cin;
   logic           r_id;
   logic [W-1:0]   r_sum;
   logic           r_cout;
   logic           r_rspValid;
`ifdef ADD_ARB_SUB_EN
   logic           r_sub;
`endif

   logic           w_grant0;
   logic           w_grant1;
   logic [31:0]    w_aSlice;
   logic [31:0]    w_bSlice;
   logic           w_sliceCin;
   logic [31:0]    w_sliceSum;
   logic           w_sliceCout;

   // Round-robin: a lone requester always wins; on contention the one that
   // was not served last wins. r_lastGrant=1 therefore favours requester 0.
   assign w_grant0 = req0_valid & (~req1_valid | r_lastGrant);
   assign w_grant1 = req1_valid & (~req0_valid | ~r_lastGrant);

   // Ready only in IDLE, and held low while reset is applied so nothing can
   // be accepted in the reset cycle.
   assign req0_ready = ~rst & (r_state == IDLE) & w_grant0;
   assign req1_ready = ~rst & (r_state == IDLE) & w_grant1;

   // Select slice k of the captured operands; the first slice takes the
   // captured carry-in, later slices take the carry registered last cycle.
   // Subtraction inverts b and injects the +1 through the first carry-in.
   always_comb begin
      w_aSlice = '0;
      w_bSlice = '0;
      for (int i = 0; i < WORDS; i++) begin
         if (r_k == 4'(i)) begin
            w_aSlice = r_a[32*i +: 32];
            w_bSlice = r_b[32*i +: 32];
         end
      end
      w_sliceCin = (r_k == 4'd0) ? r_cin : r_carry;
`ifdef ADD_ARB_SUB_EN
      if (r_sub) begin
         w_bSlice = ~w_bSlice;
         if (r_k == 4'd0) begin
            w_sliceCin = 1'b1;
         end
      end
`endif
   end

   Cla32Slice uCla (
      .i_a    (w_aSlice),
      .i_b    (w_bSlice),
      .i_cin  (w_sliceCin),
      .o_sum  (w_sliceSum),
      .o_cout (w_sliceCout)
   );

   // Control FSM and all registered outputs. Reset at any point discards the
   // operation in flight; the response registers only change in RUN, so they
   // stay frozen for the whole of DONE regardless of backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_k         <= '0;
         r_carry     <= 1'b0;
         r_lastGrant <= 1'b1;
         r_a         <= '0;
         r_b         <= '0;
         r_cin       <= 1'b0;
         r_id        <= 1'b0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_rspValid  <= 1'b0;
`ifdef ADD_ARB_SUB_EN
         r_sub       <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant0 | w_grant1) begin
                  r_id    <= w_grant1;
                  r_a     <= w_grant1 ? req1_a   : req0_a;
                  r_b     <= w_grant1 ? req1_b   : req0_b;
                  r_cin   <= w_grant1 ? req1_cin : req0_cin;
`ifdef ADD_ARB_SUB_EN
                  r_sub   <= w_grant1 ? req1_sub : req0_sub;
`endif
                  r_k     <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               for (int i = 0; i < WORDS; i++) begin
                  if (r_k == 4'(i)) begin
                     r_sum[32*i +: 32] <= w_sliceSum;
                  end
               end
               r_carry <= w_sliceCout;
               r_k     <= r_k + 4'd1;
               if (r_k == 4'(WORDS - 1)) begin
                  r_cout     <= w_sliceCout;
                  r_rspValid <= 1'b1;
                  r_state    <= DONE;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  r_rspValid  <= 1'b0;
                  r_lastGrant <= r_id;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign rsp_valid = r_rspValid;
   assign rsp_id    = r_id;
   assign rsp_sum   = r_sum;
   assign rsp_cout  = r_cout;

endmodule
